// File: rtl/serial_parity_framer.sv
// Frame parity / ones-count accumulator with valid/ready in and out.
// Ports: beat in (in_*), frame result out (out_*, par_*, len_err, ones_cnt); optional ones_cnt via PARITY_CNT_OUT_EN.
module serial_parity_framer #(
  parameter int DW        = 1,
  parameter int MAX_BEATS = 16
`ifdef PARITY_CNT_OUT_EN
  ,
  localparam int CW = $clog2(DW * MAX_BEATS + 1)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_par,
  input  logic          chk_en,
  input  logic          odd_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          par_out,
  output logic          par_err,
`ifdef PARITY_CNT_OUT_EN
  output logic [CW-1:0] ones_cnt,
`endif
  output logic          len_err
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DROP
  } state_t;

  state_t          state_q, state_d;
  logic            par_q, par_d;
  logic            odd_q, odd_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            out_valid_q, out_valid_d;
  logic            par_out_q, par_out_d;
  logic            par_err_q, par_err_d;
  logic            len_err_q, len_err_d;
  logic            acc;
  logic            beat_par;
  logic            pub;
  logic            pub_len;
  logic [BW-1:0]   beat_nxt;
`ifdef PARITY_CNT_OUT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [CW-1:0]   beat_ones;
`endif

  // A held result blocks new beats so it is never overwritten.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign beat_par = ^in_data;
  assign beat_nxt = beat_q + BW'(1);

`ifdef PARITY_CNT_OUT_EN
  always_comb begin
    beat_ones = '0;
    for (int i = 0; i < DW; i++) begin
      beat_ones = beat_ones + CW'(in_data[i]);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    odd_d    = odd_q;
    beat_d   = beat_q;
    pub      = 1'b0;
    pub_len  = 1'b0;
`ifdef PARITY_CNT_OUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          par_d  = beat_par;
          odd_d  = odd_mode;
          beat_d = BW'(1);
`ifdef PARITY_CNT_OUT_EN
          cnt_d  = beat_ones;
`endif
          if (in_last) begin
            pub = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (acc) begin
          par_d  = par_q ^ beat_par;
          beat_d = beat_nxt;
`ifdef PARITY_CNT_OUT_EN
          cnt_d  = cnt_q + beat_ones;
`endif
          if (in_last) begin
            pub     = 1'b1;
            state_d = IDLE;
          end else if (beat_nxt == BW'(MAX_BEATS)) begin
            pub     = 1'b1;
            pub_len = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (acc && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    par_out_d   = par_out_q;
    par_err_d   = par_err_q;
    len_err_d   = len_err_q;
`ifdef PARITY_CNT_OUT_EN
    ones_d      = ones_q;
`endif
    if (pub) begin
      out_valid_d = 1'b1;
      par_out_d   = par_d ^ odd_d;
      par_err_d   = !pub_len && chk_en && (in_par != (par_d ^ odd_d));
      len_err_d   = pub_len;
`ifdef PARITY_CNT_OUT_EN
      ones_d      = cnt_d;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      par_q       <= 1'b0;
      odd_q       <= 1'b0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
`ifdef PARITY_CNT_OUT_EN
      cnt_q       <= '0;
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      par_q       <= par_d;
      odd_q       <= odd_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      par_out_q   <= par_out_d;
      par_err_q   <= par_err_d;
      len_err_q   <= len_err_d;
`ifdef PARITY_CNT_OUT_EN
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign par_out   = par_out_q;
  assign par_err   = par_err_q;
  assign len_err   = len_err_q;
`ifdef PARITY_CNT_OUT_EN
  assign ones_cnt  = ones_q;
`endif

endmodule
